// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus sequencer: FSM encoding and
// command/address (CA) word field positions.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CA,
        ST_LATENCY,
        ST_WRITE,
        ST_READ,
        ST_CS_HOLD
    } state_t;

    localparam int ADDR_W       = 32;
    localparam int CA_W         = 48;
    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_LO    = 16;
    localparam int CA_ROW_W     = 29;
    localparam int CA_COL_W     = 3;

endpackage

// File: rtl/hyperbus_ca_gen.sv
// Builds the 48-bit HyperBus command/address word from a request.
module hyperbus_ca_gen
    import hyperbus_pkg::*;
(
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    output logic [CA_W-1:0]   ca
);

    always_comb begin
        ca                        = '0;
        ca[CA_RW_BIT]             = ~write;
        ca[CA_AS_BIT]             = 1'b0;
        ca[CA_BURST_BIT]          = 1'b1;
        ca[CA_ROW_LO +: CA_ROW_W] = addr[ADDR_W-1 -: CA_ROW_W];
        ca[CA_COL_W-1:0]          = addr[CA_COL_W-1:0];
    end

endmodule

// File: rtl/hyperbus_seq.sv
// HyperBus transaction sequencer: chip select framing, CA phase, initial
// latency and write/read data phases, driving the ioddr pins directly.
module hyperbus_seq
    import hyperbus_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 6,
    parameter int TIMEOUT = 64
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [7:0]           req_len,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [2*WIDTH-1:0]   rd_data,
    output logic                 rd_valid,
    output logic                 cs_n,
    output logic                 ck_en,
    output logic                 ddr_oe,
    output logic [2*WIDTH-1:0]   ddr_dat_o,
    input  logic [2*WIDTH-1:0]   ddr_dat_i,
    input  logic                 rwds_i,
    output logic                 busy,
    output logic                 err
);

    localparam int DW       = 2 * WIDTH;
    localparam int CA_WORDS = CA_W / DW;
    localparam int PH_W     = $clog2(LATENCY + CA_WORDS + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        word_cnt_reg;
    logic [PH_W-1:0]   ph_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [DW-1:0]     dat_o_reg;
    logic [DW-1:0]     rd_data_reg;
    logic              rd_valid_reg;

    logic              accept;
    logic              ca_last;
    logic              lat_last;
    logic              timeout;
    logic [CA_W-1:0]   ca;
    logic [DW-1:0]     ca_words [CA_WORDS];
    logic [DW-1:0]     ca_word;

    hyperbus_ca_gen u_ca_gen (
        .write (write_reg),
        .addr  (addr_reg),
        .ca    (ca)
    );

    // CA is sent most-significant word first
    genvar gi;
    generate
        for (gi = 0; gi < CA_WORDS; gi++) begin : g_ca_word
            assign ca_words[gi] = ca[CA_W-1-gi*DW -: DW];
        end
    endgenerate

    always_comb begin
        ca_word = '0;
        for (int i = 0; i < CA_WORDS; i++) begin
            if (ph_cnt_reg == PH_W'(i)) ca_word = ca_words[i];
        end
    end

    assign accept   = req_valid && req_ready;
    assign ca_last  = (ph_cnt_reg == PH_W'(CA_WORDS - 1));
    assign lat_last = (ph_cnt_reg == PH_W'(LATENCY - 1));
    assign timeout  = (state_reg == ST_READ) && !rwds_i && (to_cnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (accept) state_next = ST_CS_SETUP;
            ST_CS_SETUP: state_next = ST_CA;
            ST_CA:       if (ca_last) state_next = ST_LATENCY;
            ST_LATENCY:  if (lat_last) state_next = write_reg ? ST_WRITE : ST_READ;
            ST_WRITE:    if (wr_valid && word_cnt_reg == 8'd0) state_next = ST_CS_HOLD;
            ST_READ:     if ((rwds_i && word_cnt_reg == 8'd0) || timeout) state_next = ST_CS_HOLD;
            ST_CS_HOLD:  state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        cs_n      = 1'b1;
        ck_en     = 1'b0;
        ddr_oe    = 1'b0;
        wr_ready  = 1'b0;
        req_ready = 1'b0;
        err       = 1'b0;
        busy      = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE:     req_ready = rst_n;
            ST_CS_SETUP: cs_n = 1'b0;
            ST_CA: begin
                cs_n   = 1'b0;
                ck_en  = 1'b1;
                ddr_oe = 1'b1;
            end
            ST_LATENCY: begin
                cs_n  = 1'b0;
                ck_en = 1'b1;
            end
            ST_WRITE: begin
                cs_n     = 1'b0;
                ddr_oe   = 1'b1;
                wr_ready = 1'b1;
                ck_en    = wr_valid;
            end
            ST_READ: begin
                cs_n  = 1'b0;
                ck_en = 1'b1;
                err   = timeout && rst_n;
            end
            default: ;
        endcase
    end

    assign ddr_dat_o = (state_reg == ST_CA) ? ca_word : dat_o_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_reg    <= 1'b0;
            addr_reg     <= '0;
            word_cnt_reg <= '0;
            ph_cnt_reg   <= '0;
            to_cnt_reg   <= '0;
            dat_o_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;

            if ((state_reg == ST_CA || state_reg == ST_LATENCY) && state_next == state_reg)
                ph_cnt_reg <= ph_cnt_reg + PH_W'(1);
            else
                ph_cnt_reg <= '0;

            if (accept) begin
                write_reg    <= req_write;
                addr_reg     <= req_addr;
                word_cnt_reg <= req_len;
            end

            if (state_reg == ST_WRITE && wr_valid) begin
                dat_o_reg <= wr_data;
                if (word_cnt_reg != 8'd0) word_cnt_reg <= word_cnt_reg - 8'd1;
            end

            // Timeout counts consecutive idle READ cycles only
            if (state_reg == ST_READ) begin
                if (rwds_i) begin
                    rd_data_reg  <= ddr_dat_i;
                    rd_valid_reg <= 1'b1;
                    to_cnt_reg   <= '0;
                    if (word_cnt_reg != 8'd0) word_cnt_reg <= word_cnt_reg - 8'd1;
                end else begin
                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

endmodule
